// File: rtl/demux_rr_sched_if.sv
// Handshake bundle between one producer, the round-robin burst scheduler and four sinks.
// The master side drives stimulus and sink readiness; the slave side is the scheduler.
interface demux_rr_sched_if #(
  parameter int DW = 8
);
  logic [3:0]    en_mask;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ready;
  logic [1:0]    sel;
  logic          busy;

  modport master (
    output en_mask, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel, busy
  );

  modport slave (
    input  en_mask, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler for a 1-to-4 demux: BURST beats go to one enabled sink
// through a single output slot, then the next enabled sink is picked.
module demux_rr_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic             clk,
  input logic             rst,
  demux_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } state_t;

  localparam logic [7:0] LastBeat = 8'(BURST - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sel;
  logic [1:0]    r_last;
  logic [7:0]    r_beat_cnt;
  logic          r_slot_valid;
  logic [DW-1:0] r_slot_data;

  logic [1:0]    w_sel_nxt;
  logic [1:0]    w_last_nxt;
  logic [7:0]    w_beat_cnt_nxt;
  logic [1:0]    w_pick_base;
  logic [1:0]    w_pick;
  logic          w_any_en;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_drain;

  assign w_any_en = |bus.en_mask;
  assign w_drain  = r_slot_valid & bus.out_ready[r_sel];

  // In DRAIN the sink just finished becomes "last", so the scan starts after it.
  assign w_pick_base = (r_state == DRAIN) ? r_sel : r_last;

  always_comb begin
    w_pick = w_pick_base;
    if (bus.en_mask[w_pick_base + 2'd1])
      w_pick = w_pick_base + 2'd1;
    else if (bus.en_mask[w_pick_base + 2'd2])
      w_pick = w_pick_base + 2'd2;
    else if (bus.en_mask[w_pick_base + 2'd3])
      w_pick = w_pick_base + 2'd3;
    else if (bus.en_mask[w_pick_base])
      w_pick = w_pick_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= 2'd0;
      r_last     <= 2'd3;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_last     <= w_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_last_nxt     = r_last;
    w_beat_cnt_nxt = r_beat_cnt;
    w_in_ready     = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_en) begin
          w_sel_nxt      = w_pick;
          w_beat_cnt_nxt = 8'd0;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        w_in_ready = ~r_slot_valid | bus.out_ready[r_sel];
        w_accept   = bus.in_valid & w_in_ready;
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          if (r_beat_cnt == LastBeat)
            w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Rotation waits for the last beat to leave so sel never moves under a full slot.
        if (!r_slot_valid || w_drain) begin
          w_last_nxt = r_sel;
          if (w_any_en) begin
            w_sel_nxt      = w_pick;
            w_beat_cnt_nxt = 8'd0;
            w_state_nxt    = SEND;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A drain and an accept in the same cycle keep the slot full with the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_slot_data  <= '0;
    end else if (w_accept) begin
      r_slot_valid <= 1'b1;
      r_slot_data  <= bus.in_data;
    end else if (w_drain) begin
      r_slot_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_slot_valid ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.out_data  = r_slot_data;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: a per-cycle vector table for the all-enabled rotation,
// plus stream sequences for masking, stalls, reset mid-burst and BURST=1.
module tb_demux_rr_sched;

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       expReady;
    logic [3:0] expValid;
    logic [7:0] expData;
    logic [1:0] expSel;
    logic       expBusy;
  } vec_t;

  typedef struct packed {
    logic       r;
    logic [3:0] v;
    logic [7:0] d;
    logic [1:0] s;
    logic       b;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux_rr_sched_if #(.DW(8)) bus4 ();
  demux_rr_sched_if #(.DW(8)) bus1 ();

  demux_rr_sched #(.DW(8), .BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  demux_rr_sched #(.DW(8), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int         errors = 0;
  int         checks = 0;
  bit         useB1 = 1'b0;
  int         accepted;
  int         b2b;
  logic [3:0] validSeen;
  logic [3:0] selSeen;
  logic [3:0] holdValid;
  logic [7:0] holdData;
  obs_t       lastObs;
  int         dSink[$];
  logic [7:0] dData[$];
  int         eSink[$];
  logic [7:0] eData[$];
  vec_t       tbl[22];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input logic [3:0] en, input logic v, input logic [7:0] d,
                             input logic [3:0] rdy);
    bus4.en_mask = en; bus4.in_valid = v; bus4.in_data = d; bus4.out_ready = rdy;
    bus1.en_mask = en; bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = rdy;
  endtask

  function automatic obs_t readOut();
    obs_t o;
    if (useB1) o = '{bus1.in_ready, bus1.out_valid, bus1.out_data, bus1.sel, bus1.busy};
    else       o = '{bus4.in_ready, bus4.out_valid, bus4.out_data, bus4.sel, bus4.busy};
    return o;
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 7;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] en, input logic v, input logic [7:0] d,
                              input logic [3:0] rdy, input logic er, input logic [3:0] ev,
                              input logic [7:0] ed, input logic [1:0] es, input logic eb);
    vec_t t;
    t = '{en, v, d, rdy, er, ev, ed, es, eb};
    return t;
  endfunction

  task automatic doReset(input string name);
    obs_t o;
    @(negedge clk);
    rst = 1'b1;
    driveInputs(4'h0, 1'b0, 8'h00, 4'h0);
    #1;
    o = readOut();
    checkVal(name, 32'(o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expectPush(input int s, input logic [7:0] d);
    eSink.push_back(s);
    eData.push_back(d);
  endtask

  task automatic checkDeliv(input string name);
    checkVal({name, "_count"}, 32'(dSink.size()), 32'(eSink.size()));
    for (int i = 0; i < eSink.size() && i < dSink.size(); i++)
      checkVal($sformatf("%s_beat%0d", name, i), {16'(dSink[i]), 8'h00, dData[i]},
               {16'(eSink[i]), 8'h00, eData[i]});
    eSink.delete();
    eData.delete();
  endtask

  task automatic runStream(input int nBeats, input logic [7:0] base, input int nCycles,
                           input logic [3:0] enA, input logic [3:0] enB, input int enSwitch,
                           input int stallStart, input int stallLen);
    bit         prevAcc;
    logic [3:0] en;
    logic [3:0] rdy;
    logic       v;
    obs_t       o;
    accepted = 0; b2b = 0; validSeen = 4'h0; selSeen = 4'h0; prevAcc = 1'b0;
    dSink.delete();
    dData.delete();
    for (int c = 0; c < nCycles; c++) begin
      @(negedge clk);
      en  = (c >= enSwitch) ? enB : enA;
      rdy = (c >= stallStart && c < stallStart + stallLen) ? 4'h0 : 4'hF;
      v   = (accepted < nBeats);
      driveInputs(en, v, base + 8'(accepted), rdy);
      #1;
      o = readOut();
      lastObs = o;
      if (c >= stallStart && c < stallStart + stallLen) begin
        checkVal($sformatf("stall_hold_c%0d", c), {o.r, o.v, o.d}, {1'b0, holdValid, holdData});
      end
      validSeen |= o.v;
      if (o.b) selSeen |= 4'b0001 << o.s;
      if (v && o.r) begin
        accepted++;
        if (prevAcc) b2b++;
        prevAcc = 1'b1;
      end else begin
        prevAcc = 1'b0;
      end
      if ((o.v & rdy) != 4'h0) begin
        dSink.push_back(onehotIdx(o.v));
        dData.push_back(o.d);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    obs_t o;

    // en, v, d, rdy | in_ready, out_valid, out_data, sel, busy
    tbl[0]  = mk(4'hF, 1, 8'h00, 4'hF, 0, 4'h0, 8'h00, 2'd0, 0);
    tbl[1]  = mk(4'hF, 1, 8'h00, 4'hF, 1, 4'h0, 8'h00, 2'd0, 1);
    tbl[2]  = mk(4'hF, 1, 8'h01, 4'hF, 1, 4'h1, 8'h00, 2'd0, 1);
    tbl[3]  = mk(4'hF, 1, 8'h02, 4'hF, 1, 4'h1, 8'h01, 2'd0, 1);
    tbl[4]  = mk(4'hF, 1, 8'h03, 4'hF, 1, 4'h1, 8'h02, 2'd0, 1);
    tbl[5]  = mk(4'hF, 1, 8'h04, 4'hF, 0, 4'h1, 8'h03, 2'd0, 1);
    tbl[6]  = mk(4'hF, 1, 8'h04, 4'hF, 1, 4'h0, 8'h03, 2'd1, 1);
    tbl[7]  = mk(4'hF, 1, 8'h05, 4'hF, 1, 4'h2, 8'h04, 2'd1, 1);
    tbl[8]  = mk(4'hF, 1, 8'h06, 4'hF, 1, 4'h2, 8'h05, 2'd1, 1);
    tbl[9]  = mk(4'hF, 1, 8'h07, 4'hF, 1, 4'h2, 8'h06, 2'd1, 1);
    tbl[10] = mk(4'hF, 1, 8'h08, 4'hF, 0, 4'h2, 8'h07, 2'd1, 1);
    tbl[11] = mk(4'hF, 1, 8'h08, 4'hF, 1, 4'h0, 8'h07, 2'd2, 1);
    tbl[12] = mk(4'hF, 1, 8'h09, 4'hF, 1, 4'h4, 8'h08, 2'd2, 1);
    tbl[13] = mk(4'hF, 1, 8'h0A, 4'hF, 1, 4'h4, 8'h09, 2'd2, 1);
    tbl[14] = mk(4'hF, 1, 8'h0B, 4'hF, 1, 4'h4, 8'h0A, 2'd2, 1);
    tbl[15] = mk(4'hF, 1, 8'h0C, 4'hF, 0, 4'h4, 8'h0B, 2'd2, 1);
    tbl[16] = mk(4'hF, 1, 8'h0C, 4'hF, 1, 4'h0, 8'h0B, 2'd3, 1);
    tbl[17] = mk(4'hF, 1, 8'h0D, 4'hF, 1, 4'h8, 8'h0C, 2'd3, 1);
    tbl[18] = mk(4'hF, 1, 8'h0E, 4'hF, 1, 4'h8, 8'h0D, 2'd3, 1);
    tbl[19] = mk(4'hF, 1, 8'h0F, 4'hF, 1, 4'h8, 8'h0E, 2'd3, 1);
    tbl[20] = mk(4'hF, 0, 8'h00, 4'hF, 0, 4'h8, 8'h0F, 2'd3, 1);
    tbl[21] = mk(4'hF, 0, 8'h00, 4'hF, 1, 4'h0, 8'h0F, 2'd0, 1);

    $display("[TB] all-enabled rotation, BURST=4");
    useB1 = 1'b0;
    doReset("reset_b4");
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      driveInputs(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].rdy);
      #1;
      o = readOut();
      checkVal($sformatf("table_row%0d", i), 32'(o),
               32'({tbl[i].expReady, tbl[i].expValid, tbl[i].expData, tbl[i].expSel,
                    tbl[i].expBusy}));
    end

    $display("[TB] en_mask=1010 alternation");
    doReset("reset_t2");
    runStream(12, 8'h00, 20, 4'hA, 4'hA, 1000, -1, 0);
    for (int i = 0; i < 12; i++) expectPush(((i / 4) % 2 == 0) ? 1 : 3, 8'(i));
    checkDeliv("t2");
    checkVal("t2_valid_seen", 32'(validSeen), 32'h0000000A);
    checkVal("t2_sel_seen", 32'(selSeen), 32'h0000000A);

    $display("[TB] five-cycle stall mid-burst");
    doReset("reset_t3");
    holdValid = 4'b0001;
    holdData  = 8'h01;
    runStream(16, 8'h00, 30, 4'hF, 4'hF, 1000, 3, 5);
    for (int i = 0; i < 16; i++) expectPush(i / 4, 8'(i));
    checkDeliv("t3");

    $display("[TB] mask cleared mid-burst");
    doReset("reset_t4");
    runStream(8, 8'h00, 10, 4'h1, 4'h0, 2, -1, 0);
    checkVal("t4_accepted", 32'(accepted), 32'd4);
    for (int i = 0; i < 4; i++) expectPush(0, 8'(i));
    checkDeliv("t4");
    checkVal("t4_idle_busy_ready_valid", {lastObs.b, lastObs.r, lastObs.v}, 32'h0);

    $display("[TB] reset with a full slot");
    doReset("reset_t5");
    runStream(6, 8'h00, 8, 4'hF, 4'hF, 1000, -1, 0);
    for (int i = 0; i < 5; i++) expectPush((i < 4) ? 0 : 1, 8'(i));
    checkDeliv("t5_pre");
    @(negedge clk);
    #1;
    o = readOut();
    checkVal("t5_slot_full", {o.v, o.d, 6'(o.s)}, {4'b0010, 8'h05, 6'd1});
    rst = 1'b1;
    driveInputs(4'h0, 1'b0, 8'h00, 4'h0);
    #1;
    o = readOut();
    checkVal("t5_after_rst", 32'(o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    runStream(4, 8'h20, 8, 4'hF, 4'hF, 1000, -1, 0);
    for (int i = 0; i < 4; i++) expectPush(0, 8'h20 + 8'(i));
    checkDeliv("t5_post");

    $display("[TB] BURST=1 single sink 2");
    useB1 = 1'b1;
    doReset("reset_b1");
    runStream(4, 8'h40, 10, 4'h4, 4'h4, 1000, -1, 0);
    checkVal("t6_accepted", 32'(accepted), 32'd4);
    checkVal("t6_back_to_back", 32'(b2b), 32'd0);
    checkVal("t6_sel_seen", 32'(selSeen), 32'h4);
    checkVal("t6_valid_seen", 32'(validSeen), 32'h4);
    for (int i = 0; i < 4; i++) expectPush(2, 8'h40 + 8'(i));
    checkDeliv("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
